// File: rtl/square_seq_if.sv
// Bundle of the radicand input, square-root core and result channels of square_seq.
// slave is the square_seq view; master is the surrounding environment.
interface square_seq_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        sq_start;
  logic [2:0]  sq_mode;
  logic [15:0] sq_data;
  logic [7:0]  sq_root;
  logic [8:0]  sq_rem;
  logic        sq_finish;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_radicand;
  logic [7:0]  out_root;
  logic [8:0]  out_rem;
  logic        out_err;

  modport slave (
    input  in_valid, in_data, sq_root, sq_rem, sq_finish, out_ready,
    output in_ready, sq_start, sq_mode, sq_data,
           out_valid, out_radicand, out_root, out_rem, out_err
  );

  modport master (
    output in_valid, in_data, sq_root, sq_rem, sq_finish, out_ready,
    input  in_ready, sq_start, sq_mode, sq_data,
           out_valid, out_radicand, out_root, out_rem, out_err
  );
endinterface

// File: rtl/square_seq.sv
// Buffers radicands in a small FIFO, issues them one at a time to an external
// square-root core, self-checks the returned root/remainder and presents the result.
module square_seq #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64,
  parameter logic [2:0]  MODE    = 3'd0
) (
  input logic         clk,
  input logic         rst,
  square_seq_if.slave bus
);
  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned WCW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]  FULL_CNT  = CW'(DEPTH);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [15:0]     sq_data_q, sq_data_d;
  logic [15:0]     out_radicand_q, out_radicand_d;
  logic [7:0]      out_root_q, out_root_d;
  logic [8:0]      out_rem_q, out_rem_d;
  logic            out_err_q, out_err_d;
  logic            in_ready_s;
  logic            push_s;
  logic            pop_s;

  // A result is bad when root^2 + rem misses the radicand or rem exceeds 2*root.
  function automatic logic check_fail(input logic [15:0] rad,
                                      input logic [7:0]  root,
                                      input logic [8:0]  rem);
    logic [16:0] recon;
    recon = ({9'd0, root} * {9'd0, root}) + {8'd0, rem};
    return (recon != {1'b0, rad}) || ({8'd0, rem} > {8'd0, root, 1'b0});
  endfunction

  assign in_ready_s = (count_q != FULL_CNT);
  assign push_s     = bus.in_valid && in_ready_s;

  // FIFO pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      wr_ptr_d = wr_ptr_q + AW'(1'b1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + AW'(1'b1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1'b1);
      2'b01:   count_d = count_q - CW'(1'b1);
      default: count_d = count_q;
    endcase
  end

  // Sequencer next-state and result capture.
  always_comb begin
    state_d        = state_q;
    pop_s          = 1'b0;
    wcnt_d         = wcnt_q;
    sq_data_d      = sq_data_q;
    out_radicand_d = out_radicand_q;
    out_root_d     = out_root_q;
    out_rem_d      = out_rem_q;
    out_err_d      = out_err_q;
    case (state_q)
      IDLE: begin
        if (count_q != {CW{1'b0}}) begin
          pop_s     = 1'b1;
          sq_data_d = mem_q[rd_ptr_q];
          state_d   = ISSUE;
        end else begin
          state_d = IDLE;
        end
      end
      ISSUE: begin
        wcnt_d  = {WCW{1'b0}};
        state_d = WAIT;
      end
      WAIT: begin
        if (bus.sq_finish) begin
          out_radicand_d = sq_data_q;
          out_root_d     = bus.sq_root;
          out_rem_d      = bus.sq_rem;
          out_err_d      = check_fail(sq_data_q, bus.sq_root, bus.sq_rem);
          state_d        = OUT;
        end else if (wcnt_q == WAIT_LAST) begin
          // Core never answered: report an errored, zeroed result.
          out_radicand_d = sq_data_q;
          out_root_d     = 8'd0;
          out_rem_d      = 9'd0;
          out_err_d      = 1'b1;
          state_d        = OUT;
        end else begin
          wcnt_d = wcnt_q + WCW'(1'b1);
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end else begin
          state_d = OUT;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, pointer and result registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      wr_ptr_q       <= {AW{1'b0}};
      rd_ptr_q       <= {AW{1'b0}};
      count_q        <= {CW{1'b0}};
      wcnt_q         <= {WCW{1'b0}};
      sq_data_q      <= 16'd0;
      out_radicand_q <= 16'd0;
      out_root_q     <= 8'd0;
      out_rem_q      <= 9'd0;
      out_err_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
      wcnt_q         <= wcnt_d;
      sq_data_q      <= sq_data_d;
      out_radicand_q <= out_radicand_d;
      out_root_q     <= out_root_d;
      out_rem_q      <= out_rem_d;
      out_err_q      <= out_err_d;
    end
  end

  // FIFO storage; contents are meaningless while the occupancy is zero.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.in_ready     = in_ready_s;
  assign bus.sq_start     = (state_q == ISSUE);
  assign bus.sq_mode      = MODE;
  assign bus.sq_data      = sq_data_q;
  assign bus.out_valid    = (state_q == OUT);
  assign bus.out_radicand = out_radicand_q;
  assign bus.out_root     = out_root_q;
  assign bus.out_rem      = out_rem_q;
  assign bus.out_err      = out_err_q;
endmodule
